game_round_ctrl: RTL



---
 rtl/game_round_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/game_round_ctrl.sv
//------------------------------------------------------------------------------
// Module   : game_round_ctrl
// Brief    : Round sequencer for the countdown-timer game. Drives the timer's
//            config/game buttons, arbitrates guesses against expiry and keeps
//            score and remaining attempts.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module game_round_ctrl #(
  parameter int PULSE_CYCLES = 4,
  parameter int MAX_ATTEMPTS = 3,
  parameter int DEFAULT_DEC  = 3,
  parameter int DEFAULT_SEC  = 0
) (
  input  logic       clk_50Mhz,
  input  logic       reset,
  input  logic       load_pb,
  input  logic       start_pb,
  input  logic [3:0] sw_dec,
  input  logic [3:0] sw_sec,
  input  logic       guess_valid,
  input  logic       guess_match,
  input  logic       timer_active,
  input  logic [3:0] timer_dec,
  input  logic [3:0] timer_sec,
  output logic       timer_config_n,
  output logic       timer_game_n,
  output logic       timer_rst,
  output logic [3:0] cfg_dec,
  output logic [3:0] cfg_sec,
  output logic [2:0] state,
  output logic [1:0] attempts_left,
  output logic [7:0] score,
  output logic       win_led,
  output logic       lose_led
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_START = 3'd2,
    S_ARMED = 3'd3,
    S_PLAY  = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_t;

  localparam logic [7:0] c_pulse_last  = 8'(PULSE_CYCLES - 1);
  localparam logic [1:0] c_max_attempt = 2'(MAX_ATTEMPTS);
  localparam logic [3:0] c_default_dec = 4'(DEFAULT_DEC);
  localparam logic [3:0] c_default_sec = 4'(DEFAULT_SEC);

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pulse_cnt;
  logic [7:0] w_pulse_cnt_nxt;
  logic [3:0] r_cfg_dec;
  logic [3:0] w_cfg_dec_nxt;
  logic [3:0] r_cfg_sec;
  logic [3:0] w_cfg_sec_nxt;
  logic [1:0] r_attempts;
  logic [1:0] w_attempts_nxt;
  logic [7:0] r_score;
  logic [7:0] w_score_nxt;
  logic       r_config_n;
  logic       r_game_n;
  logic       r_timer_rst;
  logic       r_win_led;
  logic       r_lose_led;

  logic [3:0] w_dec9;
  logic [3:0] w_sec9;
  logic [8:0] w_score_sum;
  logic [7:0] w_score_sat;
  logic       w_round_end;

  assign w_dec9      = bcd_clamp(timer_dec);
  assign w_sec9      = bcd_clamp(timer_sec);
  assign w_score_sum = {1'b0, r_score} + ({5'd0, w_dec9} * 9'd10) + {5'd0, w_sec9};
  assign w_score_sat = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

  always_comb begin
    w_state_nxt     = r_state;
    w_pulse_cnt_nxt = r_pulse_cnt;
    w_cfg_dec_nxt   = r_cfg_dec;
    w_cfg_sec_nxt   = r_cfg_sec;
    w_attempts_nxt  = r_attempts;
    w_score_nxt     = r_score;
    case (r_state)
      S_IDLE: begin
        if (load_pb) begin
          w_cfg_dec_nxt = bcd_clamp(sw_dec);
          w_cfg_sec_nxt = bcd_clamp(sw_sec);
        end
        if (start_pb) begin
          w_state_nxt     = S_CFG;
          w_pulse_cnt_nxt = 8'd0;
          w_attempts_nxt  = c_max_attempt;
        end
      end
      S_CFG: begin
        if (r_pulse_cnt == c_pulse_last) begin
          w_state_nxt     = S_START;
          w_pulse_cnt_nxt = 8'd0;
        end else begin
          w_pulse_cnt_nxt = r_pulse_cnt + 8'd1;
        end
      end
      S_START: begin
        if (r_pulse_cnt == c_pulse_last) begin
          w_state_nxt     = S_ARMED;
          w_pulse_cnt_nxt = 8'd0;
        end else begin
          w_pulse_cnt_nxt = r_pulse_cnt + 8'd1;
        end
      end
      S_ARMED: begin
        if (timer_active) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        // A guess outranks a simultaneous timer expiry
        if (guess_valid && guess_match) begin
          w_state_nxt = S_WIN;
          w_score_nxt = w_score_sat;
        end else if (guess_valid) begin
          if (r_attempts <= 2'd1) begin
            w_attempts_nxt = 2'd0;
            w_state_nxt    = S_LOSE;
          end else begin
            w_attempts_nxt = r_attempts - 2'd1;
          end
        end else if (!timer_active) begin
          w_state_nxt = S_LOSE;
        end
      end
      S_WIN, S_LOSE: begin
        if (start_pb) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_round_end = (r_state == S_PLAY) &&
                       ((w_state_nxt == S_WIN) || (w_state_nxt == S_LOSE));

  // Button levels are decoded from the next state so they line up with it
  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pulse_cnt <= 8'd0;
      r_cfg_dec   <= c_default_dec;
      r_cfg_sec   <= c_default_sec;
      r_attempts  <= c_max_attempt;
      r_score     <= 8'd0;
      r_config_n  <= 1'b1;
      r_game_n    <= 1'b1;
      r_timer_rst <= 1'b0;
      r_win_led   <= 1'b0;
      r_lose_led  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pulse_cnt <= w_pulse_cnt_nxt;
      r_cfg_dec   <= w_cfg_dec_nxt;
      r_cfg_sec   <= w_cfg_sec_nxt;
      r_attempts  <= w_attempts_nxt;
      r_score     <= w_score_nxt;
      r_config_n  <= (w_state_nxt != S_CFG);
      r_game_n    <= (w_state_nxt != S_START);
      r_timer_rst <= w_round_end;
      r_win_led   <= (w_state_nxt == S_WIN);
      r_lose_led  <= (w_state_nxt == S_LOSE);
    end
  end

  assign timer_config_n = r_config_n;
  assign timer_game_n   = r_game_n;
  assign timer_rst      = r_timer_rst;
  assign cfg_dec        = r_cfg_dec;
  assign cfg_sec        = r_cfg_sec;
  assign state          = r_state;
  assign attempts_left  = r_attempts;
  assign score          = r_score;
  assign win_led        = r_win_led;
  assign lose_led       = r_lose_led;

endmodule

`default_nettype wire
